order_scheduler: RTL and testbench
==================================

ORDER_SCHEDULER -- requirements
Module: order_scheduler

Interface
REQ-001 Parameter TICK_DIV, default 50000000, clk cycles per auto-order tick (minimum 2).
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 enable  input  1  1 = auto generation runs; 0 = tick counter frozen.
REQ-005 gen_buy_price  input  8  current buy price from the order generator.
REQ-006 gen_sell_price  input  8  current sell price from the order generator.
REQ-007 gen_step  output  1  one-cycle pulse commanding the generator to advance one step.
REQ-008 man_valid  input  1  manual order request.
REQ-009 man_side  input  1  manual order side, 0 = buy, 1 = sell.
REQ-010 man_price  input  8  manual order price.
REQ-011 man_ready  output  1  manual order accepted this cycle.
REQ-012 ord_valid  output  1  order presented to matching engine.
REQ-013 ord_side  output  1  0 = buy, 1 = sell.
REQ-014 ord_price  output  8  order price.
REQ-015 ord_src  output  1  0 = auto, 1 = manual.
REQ-016 ord_ready  input  1  matching engine accepts order when ord_valid=1.
REQ-017 auto_drop  output  1  one-cycle pulse: a tick was lost because auto slots were still pending.

Function
REQ-018 Tick counter SHALL count 0..TICK_DIV-1 while enable=1, wrap to 0, and raise internal tick for the one cycle it holds TICK_DIV-1; it SHALL hold its value while enable=0.
REQ-019 On tick with both auto slots empty, the block SHALL capture gen_buy_price into the buy slot and gen_sell_price into the sell slot, set both pending flags, and pulse gen_step in the following cycle.
REQ-020 On tick with either auto slot still pending, the block SHALL keep existing slots unchanged, SHALL NOT pulse gen_step, and SHALL pulse auto_drop in the following cycle.
REQ-021 FSM states: IDLE, ISSUE; reset state IDLE.
REQ-022 IDLE: ord_valid=0; if any request (pend_buy, pend_sell, man_valid) exists, grant one, load ord_side/ord_price/ord_src, go to ISSUE next cycle.
REQ-023 Grant rule: auto group vs manual round-robin using a last-grant flag when both request; otherwise the sole requester wins; within the auto group buy before sell.
REQ-024 man_ready SHALL be 1 only in an IDLE cycle where manual is granted and man_valid=1; otherwise 0.
REQ-025 Granting an auto slot SHALL clear its pending flag in the same edge that loads the order register.
REQ-026 ISSUE: ord_valid=1, ord_side/ord_price/ord_src stable; on ord_valid&ord_ready go to IDLE; otherwise stay.
REQ-027 Throughput: at most one order per two cycles; handshake-to-next-ord_valid latency exactly 2 cycles when a request is waiting.
REQ-028 A tick coinciding with a grant of the last pending auto slot SHALL see slots as pending (REQ-020 applies).
REQ-029 Prices pass through unmodified, 8-bit, no arithmetic.

Reset
REQ-030 With reset=0 at a rising edge: state IDLE, tick counter 0, pending flags 0, slots 0, last-grant = manual, all outputs 0 (including statistics counter).
REQ-031 Reset asserted during ISSUE SHALL drop ord_valid at that edge; the order is discarded.

Configuration
REQ-032 Macro ORDER_SCHEDULER_STATS_EN defined: adds output ord_count (16-bit) incremented on each ord_valid&ord_ready handshake, wrapping 0xFFFF->0x0000; undefined: port and counter absent, all other behaviour identical.

Verification (TICK_DIV=4)
REQ-033 Reset release, enable=1, buy=60, sell=70, ord_ready=1 -> gen_step pulses once per 4 cycles; orders (buy,60,auto) then (sell,70,auto).
REQ-034 ord_ready held 0 for 20 cycles after first auto order -> ord_valid/data stable, auto_drop pulses at subsequent ticks, no gen_step.
REQ-035 Manual (sell,90) waiting while auto slots pending -> after reset auto buy first, then manual, then auto sell; man_ready single pulse.
REQ-036 enable=0 for 10 cycles mid-count -> tick counter frozen, no gen_step; manual orders still issued.
REQ-037 reset=0 during ISSUE -> ord_valid=0 next edge, pending flags cleared, ord_count=0 (STATS_EN).
REQ-038 STATS_EN with 65537 handshakes -> ord_count=1.

Source files
------------

// File: rtl/order_scheduler.sv
// Order scheduler: merges periodic auto buy/sell orders with manual requests into one order channel.
// Optional statistics counter (ord_count) is built when ORDER_SCHEDULER_STATS_EN is defined.
module order_scheduler #(
    parameter int TICK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] gen_buy_price,
    input  logic [7:0] gen_sell_price,
    output logic       gen_step,
    input  logic       man_valid,
    input  logic       man_side,
    input  logic [7:0] man_price,
    output logic       man_ready,
    output logic       ord_valid,
    output logic       ord_side,
    output logic [7:0] ord_price,
    output logic       ord_src,
    input  logic       ord_ready,
    output logic       auto_drop
`ifdef ORDER_SCHEDULER_STATS_EN
    ,
    output logic [15:0] ord_count
`endif
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] tick_cnt;
    logic          tick;
    logic          pend_buy, pend_sell;
    logic [7:0]    buy_slot, sell_slot;
    logic          last_man;
    logic          auto_req;
    logic          grant_auto, grant_man;

    assign tick     = enable && (tick_cnt == TICK_LAST);
    assign auto_req = pend_buy | pend_sell;

    // On contention the group that did not win last time goes first.
    assign grant_auto = auto_req & (~man_valid | last_man);
    assign grant_man  = man_valid & ~grant_auto;

    always_comb begin
        state_nxt = state;
        ord_valid = 1'b0;
        man_ready = 1'b0;
        case (state)
            IDLE: begin
                if (auto_req | man_valid)
                    state_nxt = ISSUE;
                man_ready = grant_man & reset;
            end
            ISSUE: begin
                ord_valid = 1'b1;
                if (ord_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            pend_buy  <= 1'b0;
            pend_sell <= 1'b0;
            buy_slot  <= '0;
            sell_slot <= '0;
            last_man  <= 1'b1;
            gen_step  <= 1'b0;
            auto_drop <= 1'b0;
            ord_side  <= 1'b0;
            ord_price <= '0;
            ord_src   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (enable)
                tick_cnt <= tick ? '0 : tick_cnt + 1'b1;

            // Pending flags are the registered ones, so a tick coinciding with
            // the grant of the last slot is still treated as a drop.
            gen_step  <= tick & ~auto_req;
            auto_drop <= tick & auto_req;
            if (tick && !auto_req) begin
                buy_slot  <= gen_buy_price;
                sell_slot <= gen_sell_price;
                pend_buy  <= 1'b1;
                pend_sell <= 1'b1;
            end

            if (state == IDLE) begin
                if (grant_auto) begin
                    last_man <= 1'b0;
                    ord_src  <= 1'b0;
                    if (pend_buy) begin
                        ord_side  <= 1'b0;
                        ord_price <= buy_slot;
                        pend_buy  <= 1'b0;
                    end else begin
                        ord_side  <= 1'b1;
                        ord_price <= sell_slot;
                        pend_sell <= 1'b0;
                    end
                end else if (grant_man) begin
                    last_man  <= 1'b1;
                    ord_src   <= 1'b1;
                    ord_side  <= man_side;
                    ord_price <= man_price;
                end
            end
        end
    end

`ifdef ORDER_SCHEDULER_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset)
            ord_count <= '0;
        else if (ord_valid && ord_ready)
            ord_count <= ord_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_order_scheduler.sv
// Randomized bench for order_scheduler: a queue-based reference model predicts every output each cycle.
module tb_order_scheduler;

    localparam int TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       reset, enable;
    logic [7:0] gen_buy_price, gen_sell_price;
    logic       gen_step;
    logic       man_valid, man_side;
    logic [7:0] man_price;
    logic       man_ready;
    logic       ord_valid, ord_side, ord_src;
    logic [7:0] ord_price;
    logic       ord_ready;
    logic       auto_drop;
`ifdef ORDER_SCHEDULER_STATS_EN
    logic [15:0] ord_count;
`endif

    order_scheduler #(.TICK_DIV(TICK_DIV)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .gen_buy_price  (gen_buy_price),
        .gen_sell_price (gen_sell_price),
        .gen_step       (gen_step),
        .man_valid      (man_valid),
        .man_side       (man_side),
        .man_price      (man_price),
        .man_ready      (man_ready),
        .ord_valid      (ord_valid),
        .ord_side       (ord_side),
        .ord_price      (ord_price),
        .ord_src        (ord_src),
        .ord_ready      (ord_ready),
        .auto_drop      (auto_drop)
`ifdef ORDER_SCHEDULER_STATS_EN
        ,
        .ord_count      (ord_count)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    endtask

    // Reference model: pending auto orders live in a FIFO queue, the tick is a plain modulo count.
    typedef struct packed {
        logic       side;
        logic [7:0] price;
    } ord_t;

    ord_t        m_q[$];
    int          m_tick;
    bit          m_busy, m_last_man, m_step, m_drop;
    ord_t        m_ord;
    bit          m_src;
    logic [15:0] m_cnt;
    bit          man_took;

    task automatic model_reset();
        m_q.delete();
        m_tick     = 0;
        m_busy     = 0;
        m_last_man = 1;
        m_step     = 0;
        m_drop     = 0;
        m_ord      = '0;
        m_src      = 0;
        m_cnt      = '0;
        man_took   = 0;
    endtask

    task automatic model_cycle();
        bit   has_auto, win_auto, win_man, tick, fire;
        ord_t o;
        has_auto = m_q.size() != 0;
        win_auto = 0;
        win_man  = 0;
        if (!m_busy) begin
            if (has_auto && man_valid) begin
                if (m_last_man) win_auto = 1; else win_man = 1;
            end else if (has_auto) win_auto = 1;
            else if (man_valid) win_man = 1;
        end

        chk("ord_valid", 16'(ord_valid), 16'(m_busy));
        chk("gen_step", 16'(gen_step), 16'(m_step));
        chk("auto_drop", 16'(auto_drop), 16'(m_drop));
        chk("man_ready", 16'(man_ready), 16'(win_man && reset));
        if (m_busy) begin
            chk("ord_side", 16'(ord_side), 16'(m_ord.side));
            chk("ord_price", 16'(ord_price), 16'(m_ord.price));
            chk("ord_src", 16'(ord_src), 16'(m_src));
        end
`ifdef ORDER_SCHEDULER_STATS_EN
        chk("ord_count", ord_count, m_cnt);
`endif

        if (!reset) begin
            model_reset();
            return;
        end
        man_took = win_man;
        tick = enable && (m_tick == TICK_DIV - 1);
        fire = tick && !has_auto;
        m_step = fire;
        m_drop = tick && has_auto;
        if (enable) m_tick = (m_tick + 1) % TICK_DIV;
        if (m_busy) begin
            if (ord_ready) begin
                m_busy = 0;
                m_cnt  = m_cnt + 16'd1;
            end
        end else if (win_auto) begin
            m_ord      = m_q.pop_front();
            m_src      = 0;
            m_busy     = 1;
            m_last_man = 0;
        end else if (win_man) begin
            m_ord.side  = man_side;
            m_ord.price = man_price;
            m_src       = 1;
            m_busy      = 1;
            m_last_man  = 1;
        end
        if (fire) begin
            o.side = 1'b0; o.price = gen_buy_price;  m_q.push_back(o);
            o.side = 1'b1; o.price = gen_sell_price; m_q.push_back(o);
        end
    endtask

    // Percent probabilities per cycle; a manual request is held until accepted.
    task automatic run(input int n, input int p_en, input int p_rdy, input int p_man,
                       input int p_rst, input bit fixed);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            reset     = !($urandom_range(99) < p_rst);
            enable    = ($urandom_range(99) < p_en);
            ord_ready = ($urandom_range(99) < p_rdy);
            gen_buy_price  = fixed ? 8'd60 : 8'($urandom);
            gen_sell_price = fixed ? 8'd70 : 8'($urandom);
            if (!man_valid || man_took) begin
                man_valid = ($urandom_range(99) < p_man);
                man_side  = 1'($urandom);
                man_price = 8'($urandom);
            end
            #1;
            model_cycle();
        end
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; ord_ready = 1'b0;
        gen_buy_price = '0; gen_sell_price = '0;
        man_valid = 1'b0; man_side = 1'b0; man_price = '0;
        repeat (3) @(posedge clk);
        model_reset();

        run(30, 100, 100, 0, 0, 1);      // steady auto flow, 60/70
        run(20, 100, 0, 0, 0, 1);        // stalled consumer: drops, no steps
        run(30, 100, 100, 0, 0, 1);
        man_valid = 1'b1; man_side = 1'b1; man_price = 8'd90;
        run(30, 100, 100, 0, 0, 1);      // manual sell 90 interleaves with auto
        run(10, 0, 100, 60, 0, 0);       // frozen tick counter, manual still flows
        run(400, 100, 60, 40, 0, 0);
        run(400, 70, 30, 70, 0, 0);
        for (int i = 0; i < 50 && !m_busy; i++)
            run(1, 100, 0, 50, 0, 0);
        run(1, 100, 0, 0, 100, 0);       // reset while issuing
        run(20, 100, 100, 30, 0, 0);
        run(1500, 80, 50, 50, 2, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
